obi_wishbone_bridge: RTL and testbench
======================================

Name: obi_wishbone_bridge

Overview:
Converts the core's OBI-style memory port (req/gnt/rvalid) into a classic Wishbone master port (cyc/stb/we/sel/ack). One instance serves the instruction port and one serves the data port. Each instance sits between the core and the Controller memory interface, or the top-level bus ports in simulation. Each instance allows one outstanding transaction and has a bus timeout that returns an error response.

Parameters:
ADDR_WIDTH, 32, address width on both sides
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
TIMEOUT_CYCLES, 255, number of BUS cycles without ack before an error response; 0 disables the timeout

Ports:
clk_i  input  1  core clock
rst_ni  input  1  reset, synchronous, active-low
req_i  input  1  OBI request
gnt_o  output  1  OBI grant
addr_i  input  ADDR_WIDTH  OBI address
we_i  input  1  OBI write enable
be_i  input  DATA_WIDTH/8  OBI byte enables
wdata_i  input  DATA_WIDTH  OBI write data
rvalid_o  output  1  OBI response valid
rdata_o  output  DATA_WIDTH  OBI read data
err_o  output  1  OBI error, valid with rvalid_o
wb_cyc_o  output  1  Wishbone cycle
wb_stb_o  output  1  Wishbone strobe
wb_we_o  output  1  Wishbone write enable
wb_sel_o  output  DATA_WIDTH/8  Wishbone byte select
wb_addr_o  output  ADDR_WIDTH  Wishbone address
wb_data_o  output  DATA_WIDTH  Wishbone write data
wb_data_i  input  DATA_WIDTH  Wishbone read data
wb_ack_i  input  1  Wishbone acknowledge

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low. When rst_ni=0 at a clk_i edge, the block enters IDLE.
- Reset values: every registered output is 0: wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o, rvalid_o, rdata_o, err_o. The timeout counter is 0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - gnt_o = req_i, combinational (same-cycle grant).
  - On req_i=1: capture addr_i, we_i, be_i and wdata_i into the Wishbone registers, then go to BUS.
  - wdata is captured as 0 when we_i=0.
- BUS:
  - wb_cyc_o and wb_stb_o are both 1 and held stable until the transaction ends.
  - gnt_o=0.
  - The counter increments every BUS cycle.
- On wb_ack_i=1 in BUS:
  - Register rdata_o = wb_data_i for reads, or 0 for writes. Register err_o=0.
  - Next cycle: cyc/stb=0, rvalid_o=1, go to RESP.
- Timeout:
  - Applies when TIMEOUT_CYCLES≠0, the counter reaches TIMEOUT_CYCLES-1 and wb_ack_i=0.
  - Action: drop cyc/stb, rdata_o=0, err_o=1, go to RESP.
  - If ack and the timeout condition occur in the same cycle, ack wins and no error is reported.
- RESP:
  - rvalid_o=1 for exactly one cycle.
  - gnt_o = req_i. If granted, capture the new request and go directly to BUS; otherwise go to IDLE.
  - On leaving RESP: rvalid_o and err_o return to 0. rdata_o holds its value and is only meaningful with rvalid_o.
- Latency: with a zero-wait slave (ack in the first BUS cycle), grant is at cycle N, cyc/stb at N+1, rvalid at N+2. Back-to-back throughput is one transaction per 2 cycles.
- wb_ack_i outside BUS is ignored. No state change and no rvalid result from it.
- Counter is cleared on every entry into BUS.
- Reset mid-transaction: cyc/stb drop in the next cycle and no rvalid is emitted for the aborted request.
- Address and byte-enables pass through unmodified; there is no alignment check.

Decomposition:
- Shared package obi_wb_pkg holds:
  - the state enum (IDLE, BUS, RESP);
  - localparam SEL_WIDTH = DATA_WIDTH/8;
  - the default timeout constant.
- One sub-module: bridge_timeout_counter. Ports: clk_i, rst_ni, clear, enable, limit. Output: expired.
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - expired is held at 0 when limit=0.

Test Plan:
- Reads:
  - Zero-wait read: req addr=0x100, we=0 with wb_data_i=0xDEADBEEF and ack in the first BUS cycle. Expect gnt the same cycle, cyc/stb for 1 cycle, rvalid 2 cycles after grant, rdata=0xDEADBEEF, err=0.
  - Wait-state read: ack delayed 3 cycles. Expect cyc/stb high for 4 cycles with addr stable, rvalid one cycle after ack, no rvalid earlier.
- Write: addr=0x2004, be=0b0011, wdata=0x0000CAFE. Expect wb_we_o=1, wb_sel_o=0x3, wb_data_o=0x0000CAFE, and a response with rdata=0, err=0.
- Back-to-back: 4 consecutive requests with req held high. Expect grants in IDLE and then in each RESP cycle, rvalid every 2 cycles, and responses in issue order.
- Timeout: TIMEOUT_CYCLES=4 and no ack. Expect cyc/stb high for exactly 4 cycles, then rvalid=1, err=1, rdata=0. Repeat with ack in the 4th cycle: expect err=0.
- Reset abort: assert rst_ni=0 in the 2nd BUS cycle. Expect all outputs 0 next cycle and no rvalid. A subsequent read completes normally.

Source files
------------

// File: rtl/obi_wb_pkg.sv
// ============================================================================
// Module  : obi_wb_pkg
// Purpose : Shared types and constants for the OBI-to-Wishbone bridge.
//           Holds the bridge state encoding, default widths and the
//           timeout counter width helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package obi_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } bridge_state_e;

    localparam int unsigned DEFAULT_ADDR_WIDTH     = 32;
    localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
    localparam int unsigned SEL_WIDTH              = DEFAULT_DATA_WIDTH / 8;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // A disabled timeout (0) still needs a 1-bit counter to keep ports legal.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bridge_timeout_counter.sv
// ============================================================================
// Module  : bridge_timeout_counter
// Purpose : Counts cycles spent waiting for a Wishbone acknowledge and flags
//           when the count reaches limit-1.
// Ports   : clk_i   - clock
//           rst_ni  - synchronous active-low reset
//           clear   - restart count at 0 (has priority over enable)
//           enable  - advance count by one
//           limit   - timeout length in cycles; 0 disables expiry
//           expired - high while the count equals limit-1 (limit != 0)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bridge_timeout_counter
    import obi_wb_pkg::*;
#(
    parameter  int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int unsigned CNT_W          = cnt_width(TIMEOUT_CYCLES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // The count equals the index of the current wait cycle, so limit-1 marks
    // the last cycle the bus is allowed to stay open.
    assign expired = (limit != '0) && (r_count == (limit - CNT_W'(1)));

endmodule

`default_nettype wire

// File: rtl/obi_wishbone_bridge.sv
// ============================================================================
// Module  : obi_wishbone_bridge
// Purpose : Converts an OBI request/grant/rvalid port into a classic Wishbone
//           master with one outstanding transaction and a bus timeout that
//           returns an error response.
// Ports   : clk_i, rst_ni           - clock, synchronous active-low reset
//           req_i/gnt_o             - OBI handshake (same-cycle grant)
//           addr_i/we_i/be_i/wdata_i- OBI request fields
//           rvalid_o/rdata_o/err_o  - OBI response (one-cycle pulse)
//           wb_cyc_o/wb_stb_o       - Wishbone cycle / strobe
//           wb_we_o/wb_sel_o        - Wishbone write enable / byte select
//           wb_addr_o/wb_data_o     - Wishbone address / write data
//           wb_data_i/wb_ack_i      - Wishbone read data / acknowledge
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module obi_wishbone_bridge
    import obi_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i
);

    localparam int unsigned SEL_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

    bridge_state_e          r_state;
    logic                   r_cyc;
    logic                   r_we;
    logic [SEL_W-1:0]       r_sel;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_rvalid;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_err;

    bridge_state_e          w_state_nxt;
    logic                   w_cyc_nxt;
    logic                   w_we_nxt;
    logic [SEL_W-1:0]       w_sel_nxt;
    logic [ADDR_WIDTH-1:0]  w_addr_nxt;
    logic [DATA_WIDTH-1:0]  w_wdata_nxt;
    logic                   w_rvalid_nxt;
    logic [DATA_WIDTH-1:0]  w_rdata_nxt;
    logic                   w_err_nxt;
    logic                   w_gnt;
    logic                   w_cnt_clear;
    logic                   w_expired;

    bridge_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear   (w_cnt_clear),
        .enable  (r_state == ST_BUS),
        .limit   (CNT_W'(TIMEOUT_CYCLES)),
        .expired (w_expired)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cyc_nxt    = r_cyc;
        w_we_nxt     = r_we;
        w_sel_nxt    = r_sel;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_rdata_nxt  = r_rdata;
        w_rvalid_nxt = 1'b0;
        w_err_nxt    = 1'b0;
        w_gnt        = 1'b0;
        w_cnt_clear  = 1'b0;

        case (r_state)
            // RESP accepts a new request exactly like IDLE, which is what
            // gives the two-cycle back-to-back throughput.
            ST_IDLE, ST_RESP: begin
                w_gnt = req_i;
                if (req_i) begin
                    w_addr_nxt  = addr_i;
                    w_we_nxt    = we_i;
                    w_sel_nxt   = be_i;
                    w_wdata_nxt = we_i ? wdata_i : '0;
                    w_cyc_nxt   = 1'b1;
                    w_cnt_clear = 1'b1;
                    w_state_nxt = ST_BUS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUS: begin
                // Ack is tested first so a late ack beats the timeout.
                if (wb_ack_i) begin
                    w_rdata_nxt  = r_we ? '0 : wb_data_i;
                    w_rvalid_nxt = 1'b1;
                    w_cyc_nxt    = 1'b0;
                    w_state_nxt  = ST_RESP;
                end else if (w_expired) begin
                    w_rdata_nxt  = '0;
                    w_err_nxt    = 1'b1;
                    w_rvalid_nxt = 1'b1;
                    w_cyc_nxt    = 1'b0;
                    w_state_nxt  = ST_RESP;
                end
            end
            default: begin
                w_cyc_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cyc    <= w_cyc_nxt;
            r_we     <= w_we_nxt;
            r_sel    <= w_sel_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_rdata  <= w_rdata_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign gnt_o     = w_gnt;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_we;
    assign wb_sel_o  = r_sel;
    assign wb_addr_o = r_addr;
    assign wb_data_o = r_wdata;
    assign rvalid_o  = r_rvalid;
    assign rdata_o   = r_rdata;
    assign err_o     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_obi_wishbone_bridge.sv
// ============================================================================
// Module  : tb_obi_wishbone_bridge
// Purpose : Self-checking bench for obi_wishbone_bridge with a 4-cycle bus
//           timeout. Directed scenarios plus a randomized run; expected
//           responses come from a transaction-level model kept in a queue.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_obi_wishbone_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic          gnt;
    logic [AW-1:0] addr;
    logic          we;
    logic [SW-1:0] be;
    logic [DW-1:0] wdata;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;
    logic          cyc;
    logic          stb;
    logic          wbwe;
    logic [SW-1:0] sel;
    logic [AW-1:0] wbaddr;
    logic [DW-1:0] wbdo;
    logic [DW-1:0] wbdi;
    logic          ack;

    always #5 clk = ~clk;

    obi_wishbone_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .gnt_o     (gnt),
        .addr_i    (addr),
        .we_i      (we),
        .be_i      (be),
        .wdata_i   (wdata),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .err_o     (err),
        .wb_cyc_o  (cyc),
        .wb_stb_o  (stb),
        .wb_we_o   (wbwe),
        .wb_sel_o  (sel),
        .wb_addr_o (wbaddr),
        .wb_data_o (wbdo),
        .wb_data_i (wbdi),
        .wb_ack_i  (ack)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } resp_t;

    resp_t exp_q[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cyc"},    32'(cyc),    32'd0);
        chk({tag, "_stb"},    32'(stb),    32'd0);
        chk({tag, "_we"},     32'(wbwe),   32'd0);
        chk({tag, "_sel"},    32'(sel),    32'd0);
        chk({tag, "_addr"},   wbaddr,      32'd0);
        chk({tag, "_wdata"},  wbdo,        32'd0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, "_rdata"},  rdata,       32'd0);
        chk({tag, "_err"},    32'(err),    32'd0);
    endtask

    // Issue one request in the current cycle (bridge in IDLE or RESP), act as
    // a slave that acks after `delay` wait cycles, and check the response.
    // Returns in the response cycle with req still high; the caller decides
    // whether to issue another request or go idle.
    task automatic txn(input logic [AW-1:0] a, input logic w, input logic [SW-1:0] b,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int delay);
        resp_t r;
        resp_t got;
        int    k;
        r.err   = (delay >= TO);
        r.rdata = (w || r.err) ? '0 : rd;
        exp_q.push_back(r);

        req   = 1'b1;
        addr  = a;
        we    = w;
        be    = b;
        wdata = wd;
        ack   = 1'b0;
        wbdi  = $urandom;
        #1 chk("gnt_accept", 32'(gnt), 32'd1);
        step();

        k = 0;
        while (k < TO) begin
            chk("bus_cyc",    32'(cyc),    32'd1);
            chk("bus_stb",    32'(stb),    32'd1);
            chk("bus_addr",   wbaddr,      a);
            chk("bus_we",     32'(wbwe),   32'(w));
            chk("bus_sel",    32'(sel),    32'(b));
            chk("bus_wdata",  wbdo,        w ? wd : 32'd0);
            chk("bus_rvalid", 32'(rvalid), 32'd0);
            // Scramble the OBI side: captured fields must not follow it.
            addr  = $urandom;
            wdata = $urandom;
            be    = SW'($urandom);
            we    = 1'($urandom);
            ack   = (k == delay);
            wbdi  = (k == delay) ? rd : $urandom;
            #1 chk("bus_gnt", 32'(gnt), 32'd0);
            step();
            ack = 1'b0;
            if (k == delay) break;
            k++;
        end

        got.rdata = '0;
        got.err   = 1'b0;
        if (exp_q.size() != 0) got = exp_q.pop_front();
        chk("resp_rvalid", 32'(rvalid), 32'd1);
        chk("resp_err",    32'(err),    32'(got.err));
        chk("resp_rdata",  rdata,       got.rdata);
        chk("resp_cyc",    32'(cyc),    32'd0);
    endtask

    task automatic idle(input logic ack_val);
        req = 1'b0;
        ack = ack_val;
        #1 chk("idle_gnt", 32'(gnt), 32'd0);
        step();
        ack = 1'b0;
        chk("idle_rvalid", 32'(rvalid), 32'd0);
        chk("idle_err",    32'(err),    32'd0);
        chk("idle_cyc",    32'(cyc),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        addr  = '0;
        we    = 1'b0;
        be    = '0;
        wdata = '0;
        wbdi  = '0;
        ack   = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(1'b0);

        // Zero-wait read.
        txn(32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 0);
        idle(1'b0);

        // Three wait states: ack lands in the last permitted cycle.
        txn(32'h0000_0200, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 3);
        idle(1'b0);

        // Write: response data must be zero.
        txn(32'h0000_2004, 1'b1, 4'b0011, 32'h0000_CAFE, 32'hFFFF_FFFF, 0);
        idle(1'b0);

        // Back-to-back with req held high.
        txn(32'h0000_1000, 1'b0, 4'hF, 32'h0, 32'hA0A0_0001, 0);
        txn(32'h0000_1004, 1'b1, 4'hC, 32'h5555_AAAA, 32'h0, 0);
        txn(32'h0000_1008, 1'b0, 4'h1, 32'h0, 32'hA0A0_0003, 0);
        txn(32'h0000_100C, 1'b0, 4'hF, 32'h0, 32'hA0A0_0004, 0);
        idle(1'b0);

        // Timeout: slave never acks.
        txn(32'h0000_3000, 1'b0, 4'hF, 32'h0, 32'h7777_7777, 10);
        idle(1'b0);

        // Ack while idle must be ignored.
        idle(1'b1);
        idle(1'b0);

        // Reset in the second BUS cycle aborts the request.
        req   = 1'b1;
        addr  = 32'h0000_4000;
        we    = 1'b0;
        be    = 4'hF;
        wdata = 32'h0;
        #1 chk("abort_gnt", 32'(gnt), 32'd1);
        step();
        req = 1'b0;
        chk("abort_bus0_cyc", 32'(cyc), 32'd1);
        step();
        chk("abort_bus1_cyc", 32'(cyc), 32'd1);
        rst_n = 1'b0;
        step();
        chk_all_zero("abort");
        rst_n = 1'b1;
        idle(1'b0);
        idle(1'b0);
        txn(32'h0000_4004, 1'b0, 4'hF, 32'h0, 32'hC0DE_0001, 1);
        idle(1'b0);

        // Randomized traffic, mixing idle gaps and back-to-back issue.
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] ra;
            logic          rw;
            logic [SW-1:0] rb;
            logic [DW-1:0] rwd;
            logic [DW-1:0] rrd;
            int            rdl;
            ra  = $urandom;
            rw  = 1'($urandom);
            rb  = SW'($urandom);
            rwd = $urandom;
            rrd = $urandom;
            rdl = int'($urandom_range(0, 5));
            txn(ra, rw, rb, rwd, rrd, rdl);
            if ($urandom_range(0, 1) == 0) idle(1'b0);
        end
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
